code_entry_unit: RTL and testbench
==================================

CODE_ENTRY_UNIT -- requirements
Module: code_entry_unit

Interface
REQ-001 Parameters, one per line: name, default, meaning.
 - CODE_LEN, 4, number of digits per code.
 - DIGIT_W, 4, bits per digit (BCD).
 - DEFAULT_CODE, 16'h1234, stored code after reset.
REQ-002 Clock is "clock"; reset is "reset"; single clock; reset is synchronous and active-high.
REQ-003 Ports, one per line: name, direction, width, meaning.
 - clock, in, 1, rising-edge clock.
 - reset, in, 1, synchronous active-high reset.
 - digit_valid, in, 1, one-cycle strobe qualifying digit.
 - digit, in, DIGIT_W, keypad digit.
 - clear_btn, in, 1, raw level button; discards the partial entry.
 - enter_btn, in, 1, raw level button.
 - change_btn, in, 1, raw level button.
 - enable, in, 1, load request from the lock FSM; the code is stored on this.
 - enter, out, 1, one-cycle pulse to the lock FSM.
 - change, out, 1, one-cycle pulse to the lock FSM.
 - Compare, out, 1, buffer full and equal to the stored code.
 - digit_count, out, 3, digits currently buffered (0..CODE_LEN).
 - bad_digit, out, 1, one-cycle pulse when a digit is rejected.

Function
REQ-004 Each raw button SHALL pass through a 2-flop synchronizer; the pulse output fires one cycle on a synchronized 0->1 edge, 3 cycles after the raw rise.
REQ-005 Holding a button SHALL produce exactly one pulse; no new pulse until the button is released and pressed again.
REQ-006 FSM states: EMPTY (count 0), COLLECT (1..CODE_LEN-1), FULL (count CODE_LEN), FLUSH (one cycle).
REQ-007 Digit accept rule: digit_valid=1, digit<=9, state EMPTY or COLLECT.
 - digit shifts into the buffer LSB; previous digits move toward the MSB.
 - digit_count increments the next cycle.
REQ-008 Digit reject rule: digit_valid with digit>9 SHALL pulse bad_digit the next cycle; buffer unchanged.
REQ-009 digit_valid in FULL or FLUSH SHALL be ignored silently; no bad_digit.
REQ-010 Compare = (state==FULL) && (buffer==stored_code); driven from registers only, valid the cycle after the last digit is accepted.
REQ-011 Compare is held while the enter or change pulse is high, so the FSM samples a stable value.
REQ-012 An enter or change pulse in any state SHALL move to FLUSH the next cycle.
 - FLUSH clears the buffer and count to 0 and forces Compare=0.
 - FLUSH goes to EMPTY after one cycle.
REQ-013 enable=1 in the same cycle as an enter or change pulse, with state FULL: stored_code <= buffer.
REQ-014 enable=1 with state not FULL SHALL leave stored_code unchanged.
REQ-015 enable without a coincident pulse SHALL have no effect.
REQ-016 clear pulse in EMPTY, COLLECT or FULL SHALL clear the buffer and go to EMPTY the next cycle.
REQ-017 Simultaneous events, priority: enter/change > clear > digit_valid.
 - Simultaneous enter and change SHALL pass both pulses through unchanged.
REQ-018 Buffer width is CODE_LEN*DIGIT_W; compare is a full-width equality with no partial match.

Reset
REQ-019 reset=1 at a clock edge, including mid-entry and in FLUSH:
 - state = EMPTY; buffer = 0; digit_count = 0.
 - stored_code = DEFAULT_CODE.
 - enter, change, Compare, bad_digit = 0.
 - synchronizer and edge flops = 0.
REQ-020 A button held through reset release SHALL NOT pulse until it is released and pressed again.

Structure
REQ-021 The shared package lock_pkg holds:
 - the state enum (EMPTY, COLLECT, FULL, FLUSH);
 - CODE_LEN, DIGIT_W and DEFAULT_CODE;
 - the MAX_DIGIT=9 constant.
REQ-022 The sub-module btn_pulse (synchronizer plus rising-edge detector) is instantiated three times; all other logic stays in code_entry_unit.

Verification
REQ-023 After reset, digits 1,2,3,4 then an enter press:
 - Compare=1 from the cycle after digit 4;
 - enter pulses with Compare=1;
 - digit_count=0 two cycles later.
REQ-024 Digits 1,2,3,5 then change:
 - Compare=0 throughout;
 - change pulses once;
 - buffer flushed.
REQ-025 Digits 9,8,7,6, then an enter press with enable=1 in the pulse cycle; re-enter 9,8,7,6:
 - stored_code=16'h9876;
 - Compare=1 on the re-entry.
REQ-026 Digits 1,2 then digit 4'hA:
 - bad_digit pulses;
 - digit_count stays 2;
 - a fifth digit after four valid digits is ignored, with no bad_digit.
REQ-027 enter_btn held for 20 cycles -> exactly one enter pulse.
REQ-028 Reset asserted after 3 digits and after a code change:
 - digit_count=0;
 - stored_code back to 16'h1234.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared definitions for the keypad code-entry path: entry FSM states and code geometry.
package lock_pkg;
    localparam int CODE_LEN  = 4;
    localparam int DIGIT_W   = 4;
    localparam int MAX_DIGIT = 9;
    localparam logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234;

    typedef enum logic [1:0] {
        EMPTY,
        COLLECT,
        FULL,
        FLUSH
    } entry_state_t;
endpackage

// File: rtl/code_entry_unit_if.sv
// Keypad/button side and lock-FSM side signals of the code entry unit.
interface code_entry_unit_if;
    import lock_pkg::*;

    logic               digit_valid;
    logic [DIGIT_W-1:0] digit;
    logic               clear_btn;
    logic               enter_btn;
    logic               change_btn;
    logic               enable;
    logic               enter;
    logic               change;
    logic               Compare;
    logic [2:0]         digit_count;
    logic               bad_digit;

    modport master (
        output digit_valid, digit, clear_btn, enter_btn, change_btn, enable,
        input  enter, change, Compare, digit_count, bad_digit
    );

    modport slave (
        input  digit_valid, digit, clear_btn, enter_btn, change_btn, enable,
        output enter, change, Compare, digit_count, bad_digit
    );
endinterface

// File: rtl/btn_pulse.sv
// Two-flop synchronizer plus registered rising-edge detector for a raw button level.
module btn_pulse (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic pulse
);
    logic       sync1_reg;
    logic       sync2_reg;
    logic       prev_reg;
    logic       armed_reg;
    logic       pulse_reg;
    logic [1:0] fill_reg;

    // armed_reg only sets once the synchronizer holds a genuine released level,
    // so a button held through reset cannot fire until it is released.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
            armed_reg <= 1'b0;
            pulse_reg <= 1'b0;
            fill_reg  <= 2'b00;
        end else begin
            sync1_reg <= btn_raw;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            fill_reg  <= {fill_reg[0], 1'b1};
            if (fill_reg[1] && !sync2_reg) begin
                armed_reg <= 1'b1;
            end
            pulse_reg <= sync2_reg & ~prev_reg & armed_reg;
        end
    end

    assign pulse = pulse_reg;
endmodule

// File: rtl/code_entry_unit.sv
// Collects BCD keypad digits, compares them with the stored code and turns the
// raw clear/enter/change buttons into single-cycle pulses for the lock FSM.
module code_entry_unit #(
    parameter int CODE_LEN = lock_pkg::CODE_LEN,
    parameter int DIGIT_W  = lock_pkg::DIGIT_W,
    parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = lock_pkg::DEFAULT_CODE
) (
    input logic             clock,
    input logic             reset,
    code_entry_unit_if.slave bus
);
    localparam int BUF_W = CODE_LEN * DIGIT_W;
    localparam logic [2:0]         LAST_COUNT  = 3'(CODE_LEN - 1);
    localparam logic [DIGIT_W-1:0] MAX_DIGIT_V = DIGIT_W'(lock_pkg::MAX_DIGIT);

    lock_pkg::entry_state_t state_reg, state_next;
    logic [BUF_W-1:0] buffer_reg, buffer_next;
    logic [BUF_W-1:0] stored_reg, stored_next;
    logic [2:0]       count_reg, count_next;
    logic             bad_reg, bad_next;

    logic [2:0] raw_btn;
    logic [2:0] btn_pulses;
    logic       clear_p;
    logic       enter_p;
    logic       change_p;

    assign raw_btn = {bus.change_btn, bus.enter_btn, bus.clear_btn};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_btn
            btn_pulse u_btn_pulse (
                .clock  (clock),
                .reset  (reset),
                .btn_raw(raw_btn[gi]),
                .pulse  (btn_pulses[gi])
            );
        end
    endgenerate

    assign clear_p  = btn_pulses[0];
    assign enter_p  = btn_pulses[1];
    assign change_p = btn_pulses[2];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= lock_pkg::EMPTY;
            buffer_reg <= '0;
            stored_reg <= DEFAULT_CODE;
            count_reg  <= 3'd0;
            bad_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            buffer_reg <= buffer_next;
            stored_reg <= stored_next;
            count_reg  <= count_next;
            bad_reg    <= bad_next;
        end
    end

    // Priority: enter/change, then clear, then digit entry.
    always_comb begin
        state_next  = state_reg;
        buffer_next = buffer_reg;
        stored_next = stored_reg;
        count_next  = count_reg;
        bad_next    = 1'b0;

        if (enter_p || change_p) begin
            if (bus.enable && (state_reg == lock_pkg::FULL)) begin
                stored_next = buffer_reg;
            end
            state_next  = lock_pkg::FLUSH;
            buffer_next = '0;
            count_next  = 3'd0;
        end else if (state_reg == lock_pkg::FLUSH) begin
            state_next  = lock_pkg::EMPTY;
            buffer_next = '0;
            count_next  = 3'd0;
        end else if (clear_p) begin
            state_next  = lock_pkg::EMPTY;
            buffer_next = '0;
            count_next  = 3'd0;
        end else if (bus.digit_valid &&
                     ((state_reg == lock_pkg::EMPTY) || (state_reg == lock_pkg::COLLECT))) begin
            if (bus.digit <= MAX_DIGIT_V) begin
                buffer_next = {buffer_reg[BUF_W-DIGIT_W-1:0], bus.digit};
                count_next  = count_reg + 3'd1;
                state_next  = (count_reg == LAST_COUNT) ? lock_pkg::FULL : lock_pkg::COLLECT;
            end else begin
                bad_next = 1'b1;
            end
        end
    end

    assign bus.enter       = enter_p;
    assign bus.change      = change_p;
    assign bus.Compare     = (state_reg == lock_pkg::FULL) && (buffer_reg == stored_reg);
    assign bus.digit_count = count_reg;
    assign bus.bad_digit   = bad_reg;
endmodule

// File: tb/tb_code_entry_unit.sv
// Directed self-checking bench for code_entry_unit: digit entry, compare, code change and button pulses.
module tb_code_entry_unit;
    import lock_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;

    code_entry_unit_if bus ();

    code_entry_unit dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int   checks = 0;
    int   errors = 0;
    int   enter_cnt = 0;
    int   change_cnt = 0;
    int   bad_cnt = 0;
    logic enter_cmp = 1'b0;
    logic compare_seen = 1'b0;

    // Pulse monitor, sampled on the falling edge.
    always @(negedge clock) begin
        if (bus.enter) begin
            enter_cnt = enter_cnt + 1;
            enter_cmp = bus.Compare;
        end
        if (bus.change) change_cnt = change_cnt + 1;
        if (bus.bad_digit) bad_cnt = bad_cnt + 1;
        if (bus.Compare) compare_seen = 1'b1;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_digit(input logic [3:0] d);
        bus.digit_valid = 1'b1;
        bus.digit       = d;
        tick(1);
        bus.digit_valid = 1'b0;
        bus.digit       = 4'h0;
        $display("digit %0h: count=%0d compare=%0b bad=%0b",
                 d, bus.digit_count, bus.Compare, bus.bad_digit);
    endtask

    task automatic send_code(input logic [15:0] code);
        for (int i = 3; i >= 0; i--) send_digit(code[i*4 +: 4]);
    endtask

    // sel bits: 0 clear, 1 enter, 2 change. enable is held for the whole press.
    task automatic press(input logic [2:0] sel, input int hold, input logic en);
        bus.clear_btn  = sel[0];
        bus.enter_btn  = sel[1];
        bus.change_btn = sel[2];
        bus.enable     = en;
        tick(hold);
        bus.clear_btn  = 1'b0;
        bus.enter_btn  = 1'b0;
        bus.change_btn = 1'b0;
        bus.enable     = 1'b0;
        tick(5);
        $display("press sel=%0b hold=%0d enable=%0b: enters=%0d changes=%0d count=%0d",
                 sel, hold, en, enter_cnt, change_cnt, bus.digit_count);
    endtask

    initial begin
        int base_e;
        int base_c;
        int base_b;

        bus.digit_valid = 1'b0;
        bus.digit       = 4'h0;
        bus.clear_btn   = 1'b0;
        bus.enter_btn   = 1'b0;
        bus.change_btn  = 1'b0;
        bus.enable      = 1'b0;

        // Reset state
        tick(2);
        check("rst_compare", 32'(bus.Compare), 32'd0);
        check("rst_count", 32'(bus.digit_count), 32'd0);
        check("rst_enter", 32'(bus.enter), 32'd0);
        check("rst_change", 32'(bus.change), 32'd0);
        check("rst_bad", 32'(bus.bad_digit), 32'd0);
        reset = 1'b0;
        tick(3);

        // Default code 1234 then enter, with exact pulse timing
        send_digit(4'd1);
        send_digit(4'd2);
        send_digit(4'd3);
        check("cnt3", 32'(bus.digit_count), 32'd3);
        check("cmp_partial", 32'(bus.Compare), 32'd0);
        send_digit(4'd4);
        check("cnt4", 32'(bus.digit_count), 32'd4);
        check("cmp_1234", 32'(bus.Compare), 32'd1);
        base_e = enter_cnt;
        bus.enter_btn = 1'b1;
        tick(2);
        check("enter_early", 32'(bus.enter), 32'd0);
        tick(1);
        check("enter_3cyc", 32'(bus.enter), 32'd1);
        check("cmp_held", 32'(bus.Compare), 32'd1);
        bus.enter_btn = 1'b0;
        tick(2);
        check("flush_cnt", 32'(bus.digit_count), 32'd0);
        check("flush_cmp", 32'(bus.Compare), 32'd0);
        tick(3);
        check("enter_once", 32'(enter_cnt - base_e), 32'd1);
        $display("enter 1234: enters=%0d", enter_cnt);

        // Wrong code 1235 then change
        compare_seen = 1'b0;
        base_c = change_cnt;
        base_e = enter_cnt;
        send_code(16'h1235);
        check("cnt_1235", 32'(bus.digit_count), 32'd4);
        press(3'b100, 5, 1'b0);
        check("change_once", 32'(change_cnt - base_c), 32'd1);
        check("no_enter", 32'(enter_cnt - base_e), 32'd0);
        check("cmp_never", 32'(compare_seen), 32'd0);
        check("change_flush", 32'(bus.digit_count), 32'd0);

        // enable with a partial entry leaves the stored code alone
        send_digit(4'd1);
        send_digit(4'd2);
        press(3'b010, 5, 1'b1);
        send_code(16'h1234);
        check("store_partial", 32'(bus.Compare), 32'd1);
        press(3'b001, 5, 1'b0);
        check("clear_cnt", 32'(bus.digit_count), 32'd0);

        // Store 9876 and re-enter it
        send_code(16'h9876);
        check("cmp_9876_pre", 32'(bus.Compare), 32'd0);
        press(3'b010, 5, 1'b1);
        check("enter_cmp_9876", 32'(enter_cmp), 32'd0);
        check("store_flush", 32'(bus.digit_count), 32'd0);
        send_code(16'h9876);
        check("cmp_9876", 32'(bus.Compare), 32'd1);
        press(3'b001, 5, 1'b0);
        send_code(16'h1234);
        check("cmp_old", 32'(bus.Compare), 32'd0);
        press(3'b001, 5, 1'b0);

        // Bad digit, then a fifth digit in FULL
        base_b = bad_cnt;
        send_digit(4'd9);
        send_digit(4'd8);
        send_digit(4'hA);
        check("bad_pulse", 32'(bus.bad_digit), 32'd1);
        check("bad_cnt2", 32'(bus.digit_count), 32'd2);
        tick(1);
        check("bad_one", 32'(bus.bad_digit), 32'd0);
        send_digit(4'd7);
        send_digit(4'd6);
        check("full_cnt", 32'(bus.digit_count), 32'd4);
        send_digit(4'd5);
        check("fifth_cnt", 32'(bus.digit_count), 32'd4);
        check("fifth_cmp", 32'(bus.Compare), 32'd1);
        send_digit(4'hB);
        tick(2);
        check("full_nobad", 32'(bad_cnt - base_b), 32'd1);
        press(3'b001, 5, 1'b0);

        // Long hold and simultaneous enter+change
        base_e = enter_cnt;
        press(3'b010, 20, 1'b0);
        check("hold20", 32'(enter_cnt - base_e), 32'd1);
        base_e = enter_cnt;
        base_c = change_cnt;
        press(3'b110, 5, 1'b0);
        check("both_enter", 32'(enter_cnt - base_e), 32'd1);
        check("both_change", 32'(change_cnt - base_c), 32'd1);

        // Button held through reset release
        bus.enter_btn = 1'b1;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        base_e = enter_cnt;
        tick(8);
        check("held_reset", 32'(enter_cnt - base_e), 32'd0);
        bus.enter_btn = 1'b0;
        tick(4);
        press(3'b010, 5, 1'b0);
        check("repress", 32'(enter_cnt - base_e), 32'd1);

        // Reset mid-entry after a code change
        send_code(16'h9876);
        press(3'b010, 5, 1'b1);
        send_code(16'h9876);
        check("changed_again", 32'(bus.Compare), 32'd1);
        press(3'b001, 5, 1'b0);
        send_digit(4'd1);
        send_digit(4'd2);
        send_digit(4'd3);
        check("mid_cnt", 32'(bus.digit_count), 32'd3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("mid_rst_cnt", 32'(bus.digit_count), 32'd0);
        check("mid_rst_cmp", 32'(bus.Compare), 32'd0);
        tick(3);
        send_code(16'h1234);
        check("default_back", 32'(bus.Compare), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
